// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiply issue control stage.
//   - MUL_OP_* : RV64M multiply op encodings carried on in_op.
//   - mul_state_e : issue FSM state encoding.
//   - mul_signs(op) : operand signedness {xs, ys} for a legal op.
//   - mulw_sext(v) : sign-extend a 32-bit value to 64 bits (MULW).
//   - mul_op_legal(op), mul_select(op, prod) : decode and writeback formatting.
package mul_issue_ctrl_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
    localparam logic [2:0] MUL_OP_MULW   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    // Returns {xs, ys}.
    function automatic logic [1:0] mul_signs(input logic [2:0] op);
        logic [1:0] s;
        case (op)
            MUL_OP_MULHSU: s = 2'b10;
            MUL_OP_MULHU:  s = 2'b00;
            default:       s = 2'b11;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] mulw_sext(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic mul_op_legal(input logic [2:0] op);
        return (op <= MUL_OP_MULW);
    endfunction

    // Writeback formatting from the full 128-bit product.
    function automatic logic [63:0] mul_select(input logic [2:0] op, input logic [127:0] prod);
        logic [63:0] r;
        case (op)
            MUL_OP_MUL:  r = prod[63:0];
            MUL_OP_MULW: r = mulw_sext(prod[31:0]);
            default:     r = prod[127:64];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_cache.sv
// One-entry last-product cache.
// Holds the operands {x, y, xs, ys} and the 128-bit product of the most
// recent multiplier completion and reports a hit for an identical lookup.
//   fill_i            : capture fill_* operands and fill_prod_i
//   fill_x_i/.._ys_i  : operands of the completed multiply
//   fill_prod_i       : {high, low} product
//   lk_x_i/.._ys_i    : operands of the request being looked up
//   hit_o, prod_o     : lookup result (hit_o forced 0 when CACHE_EN=0)
module mul_issue_ctrl_cache #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fill_i,
    input  logic [63:0]  fill_x_i,
    input  logic [63:0]  fill_y_i,
    input  logic         fill_xs_i,
    input  logic         fill_ys_i,
    input  logic [127:0] fill_prod_i,
    input  logic [63:0]  lk_x_i,
    input  logic [63:0]  lk_y_i,
    input  logic         lk_xs_i,
    input  logic         lk_ys_i,
    output logic         hit_o,
    output logic [127:0] prod_o
);

    logic         valid_q;
    logic [63:0]  x_q, y_q;
    logic         xs_q, ys_q;
    logic [127:0] prod_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            prod_q  <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            x_q     <= fill_x_i;
            y_q     <= fill_y_i;
            xs_q    <= fill_xs_i;
            ys_q    <= fill_ys_i;
            prod_q  <= fill_prod_i;
        end
    end

    // Signedness is part of the key: identical bit patterns give different
    // products under different signedness.
    assign hit_o  = CACHE_EN && valid_q && (x_q == lk_x_i) && (y_q == lk_y_i)
                    && (xs_q == lk_xs_i) && (ys_q == lk_ys_i);
    assign prod_o = prod_q;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Control stage between the EXU issue path and an iterative 64x64 multiplier.
// Decodes RV64M multiply ops, issues a one-cycle start, waits for completion,
// formats the writeback value and hands it downstream.
// Handshakes: a transfer happens on a cycle where valid & ready are both 1;
// valid never depends on ready, and once out_valid is raised out_result /
// out_tag hold until out_ready (or flush) ends the DONE state.
//   in_*      : request (op, operands, rd tag); in_ready only in IDLE
//   flush     : kills the in-flight request (cache contents are kept)
//   out_*     : result channel
//   m_*       : multiplier interface; m_ready is its completion strobe
//   dbg_state : current FSM state
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [63:0]      m_x,
    output logic [63:0]      m_y,
    output logic             m_xs,
    output logic             m_ys,
    output logic             m_start,
    output logic             m_stuck,
    input  logic [63:0]      m_high,
    input  logic [63:0]      m_low,
    input  logic             m_ready,
    output mul_state_e       dbg_state
);

    mul_state_e       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [63:0]      x_q, x_d, y_q, y_d;
    logic             xs_q, xs_d, ys_q, ys_d;
    logic [63:0]      result_q, result_d;

    logic [63:0]  eff_x, eff_y;
    logic [1:0]   eff_signs;
    logic         accept, cache_hit, cache_fill;
    logic [127:0] cache_prod;

    // Effective operands as the multiplier will see them.
    always_comb begin
        eff_signs = mul_signs(in_op);
        eff_x     = in_src1;
        eff_y     = in_src2;
        if (in_op == MUL_OP_MULW) begin
            eff_x = mulw_sext(in_src1[31:0]);
            eff_y = mulw_sext(in_src2[31:0]);
        end
    end

    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign accept   = in_valid && in_ready;
    // The multiplier cannot abort, so a drained product is still cached.
    assign cache_fill = m_ready && ((state_q == ST_WAIT) || (state_q == ST_DRAIN));

    mul_issue_ctrl_cache #(.CACHE_EN(CACHE_EN)) u_cache (
        .clk         (clk),
        .rst         (rst),
        .fill_i      (cache_fill),
        .fill_x_i    (x_q),
        .fill_y_i    (y_q),
        .fill_xs_i   (xs_q),
        .fill_ys_i   (ys_q),
        .fill_prod_i ({m_high, m_low}),
        .lk_x_i      (eff_x),
        .lk_y_i      (eff_y),
        .lk_xs_i     (eff_signs[1]),
        .lk_ys_i     (eff_signs[0]),
        .hit_o       (cache_hit),
        .prod_o      (cache_prod)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        x_d      = x_q;
        y_d      = y_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = in_op;
                    tag_d = in_tag;
                    x_d   = eff_x;
                    y_d   = eff_y;
                    xs_d  = eff_signs[1];
                    ys_d  = eff_signs[0];
                    if (!mul_op_legal(in_op)) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else if (cache_hit) begin
                        result_d = mul_select(in_op, cache_prod);
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (m_ready) begin
                    // Flush coinciding with completion: nothing left to drain.
                    result_d = mul_select(op_q, {m_high, m_low});
                    state_d  = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (m_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= MUL_OP_MUL;
            tag_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            xs_q     <= 1'b0;
            ys_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            result_q <= result_d;
        end
    end

    assign out_valid  = (state_q == ST_DONE) && !flush;
    assign out_result = result_q;
    assign out_tag    = tag_q;
    assign m_x        = x_q;
    assign m_y        = y_q;
    assign m_xs       = xs_q;
    assign m_ys       = ys_q;
    assign m_start    = (state_q == ST_ISSUE);
    assign m_stuck    = 1'b0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;
    import mul_issue_ctrl_pkg::*;

    localparam int TAG_W = 5;
    localparam int W     = TAG_W + 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b0;
    logic [63:0]      in_src1 = '0, in_src2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [63:0]      m_x, m_y;
    logic             m_xs, m_ys, m_start, m_stuck;
    logic [63:0]      m_high = '0, m_low = '0;
    logic             m_ready = 1'b0;
    mul_state_e       dbg_state;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    mul_issue_ctrl #(.CACHE_EN(1'b1), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .m_x(m_x), .m_y(m_y), .m_xs(m_xs), .m_ys(m_ys),
        .m_start(m_start), .m_stuck(m_stuck),
        .m_high(m_high), .m_low(m_low), .m_ready(m_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- multiplier model (34-cycle latency) ----------------
    int          starts = 0;
    bit          unstable = 1'b0;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [63:0] cx = '0, cy = '0;
    logic        cxs = 1'b0, cys = 1'b0;

    function automatic logic [127:0] mprod(input logic [63:0] x, input logic [63:0] y,
                                           input logic xs, input logic ys);
        logic [127:0] a, b;
        a = xs ? {{64{x[63]}}, x} : {64'b0, x};
        b = ys ? {{64{y[63]}}, y} : {64'b0, y};
        return a * b;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            m_ready <= 1'b0;
            cnt     <= 0;
        end else begin
            m_ready <= 1'b0;
            if (m_start) begin
                busy   <= 1'b1;
                cnt    <= 0;
                cx     <= m_x;
                cy     <= m_y;
                cxs    <= m_xs;
                cys    <= m_ys;
                starts <= starts + 1;
            end else if (busy) begin
                if (m_x !== cx || m_y !== cy || m_xs !== cxs || m_ys !== cys)
                    unstable <= 1'b1;
                if (cnt == 32) begin
                    busy    <= 1'b0;
                    m_ready <= 1'b1;
                    {m_high, m_low} <= mprod(cx, cy, cxs, cys);
                end
                cnt <= cnt + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic [127:0] ua, ub, p;
        logic [63:0]  r;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        case (op)
            3'b000: begin p = sa * sb; r = p[63:0];   end
            3'b001: begin p = sa * sb; r = p[127:64]; end
            3'b010: begin p = sa * ub; r = p[127:64]; end
            3'b011: begin p = ua * ub; r = p[127:64]; end
            3'b100: begin p = ua * ub; r = {{32{p[31]}}, p[31:0]}; end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int compared = 0;
    int failed   = 0;

    task automatic check64(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [TAG_W-1:0] tag, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check64("req_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = s1;
        in_src2  = s2;
        in_tag   = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) exp_q.push_back({tag, ref_mul(op, s1, s2)});
    endtask

    // Counts negedges after the accept until out_valid is seen.
    task automatic wait_out(input int max, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < max);
        if (!out_valid) check64("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic check_out(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check64({name, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check64({name, "_result"}, out_result, e[63:0]);
            check64({name, "_tag"}, 64'(out_tag), 64'(e[W-1:64]));
        end
    endtask

    // Full request: drive, wait, compare, let the result drain.
    task automatic run(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                       input logic [TAG_W-1:0] tag, input string name,
                       output int lat, output int sdelta);
        int s0;
        s0 = starts;
        do_req(op, s1, s2, tag, 1'b1);
        wait_out(60, lat);
        check_out(name);
        check64({name, "_inready_done"}, 64'(in_ready), 64'd0);
        sdelta = starts - s0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, sd, s0, n;
        logic [2:0]  rop;
        logic [63:0] r1, r2;

        // reset
        @(negedge clk);
        check64("rst_in_ready",  64'(in_ready),  64'd1);
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_m_start",   64'(m_start),   64'd0);
        check64("rst_out_result", out_result,    64'd0);
        check64("rst_out_tag",   64'(out_tag),   64'd0);
        check64("rst_m_stuck",   64'(m_stuck),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // basic MUL
        run(MUL_OP_MUL, 64'd3, 64'd5, 5'd3, "mul_3x5", lat, sd);
        check64("mul_3x5_starts", 64'(sd), 64'd1);
        check64("mul_3x5_lat_le40", 64'(lat <= 40), 64'd1);

        // MULH miss then MUL hit on identical operands
        run(MUL_OP_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, "mulh_m1x2", lat, sd);
        check64("mulh_starts", 64'(sd), 64'd1);
        run(MUL_OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, "mul_hit", lat, sd);
        check64("mul_hit_lat", 64'(lat), 64'd1);
        check64("mul_hit_starts", 64'(sd), 64'd0);

        run(MUL_OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, "mulhu", lat, sd);
        run(MUL_OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, "mulhsu", lat, sd);
        check64("mulhsu_starts", 64'(sd), 64'd1);

        run(MUL_OP_MULW, 64'h0000_0000_8000_0000, 64'd2, 5'd8, "mulw_a", lat, sd);
        run(MUL_OP_MULW, 64'h0000_0000_4000_0000, 64'd2, 5'd9, "mulw_b", lat, sd);

        // illegal op
        run(3'b101, 64'd7, 64'd7, 5'd10, "illegal", lat, sd);
        check64("illegal_lat", 64'(lat), 64'd1);
        check64("illegal_starts", 64'(sd), 64'd0);

        // flush mid-WAIT
        s0 = starts;
        do_req(MUL_OP_MUL, 64'd7, 64'd9, 5'd11, 1'b0);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check64("drain_out_valid", 64'(out_valid), 64'd0);
            check64("drain_in_ready", 64'(in_ready), 64'd0);
        end while (!m_ready && n < 50);
        check64("drain_m_ready_seen", 64'(m_ready), 64'd1);
        @(negedge clk);
        check64("drain_back_idle", 64'(in_ready), 64'd1);
        check64("drain_no_valid", 64'(out_valid), 64'd0);
        check64("drain_starts", 64'(starts - s0), 64'd1);
        run(MUL_OP_MUL, 64'd7, 64'd9, 5'd12, "flush_hit", lat, sd);
        check64("flush_hit_lat", 64'(lat), 64'd1);
        check64("flush_hit_starts", 64'(sd), 64'd0);

        // backpressure in DONE
        out_ready = 1'b0;
        do_req(MUL_OP_MUL, 64'd11, 64'd13, 5'd13, 1'b1);
        wait_out(60, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64("bp_valid", 64'(out_valid), 64'd1);
            check64("bp_result", out_result, 64'd143);
            check64("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        check_out("bp_release");
        @(posedge clk);
        #1;

        // async reset mid-WAIT
        do_req(MUL_OP_MUL, 64'd5, 64'd6, 5'd14, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check64("arst_out_valid", 64'(out_valid), 64'd0);
        check64("arst_in_ready", 64'(in_ready), 64'd1);
        check64("arst_m_start", 64'(m_start), 64'd0);
        check64("arst_out_result", out_result, 64'd0);
        check64("arst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(MUL_OP_MUL, 64'd5, 64'd6, 5'd15, "post_rst", lat, sd);
        check64("post_rst_starts", 64'(sd), 64'd1);

        // random legal ops
        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(0, 4));
            r1  = {$urandom, $urandom};
            r2  = {$urandom, $urandom};
            run(rop, r1, r2, 5'($urandom_range(0, 31)), "rand", lat, sd);
        end

        check64("operands_stable", 64'(unstable), 64'd0);
        check64("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
